// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port between core and debug
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK - 1);
  logic       last_gnt_q, last_gnt_d, lock_act_q, lock_act_d;
  logic       rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
  logic [7:0] starve_q, starve_d;
  logic       core_win, dbg_win, granted, win_we;
  // grant decision: a live lock under the starvation limit beats round-robin
  always_comb begin
    dbg_win  = ~reset & dbg_req & (~core_req | (lock_act_q & (starve_q < LOCK_LIM)) | ~last_gnt_q);
    core_win = ~reset & core_req & ~dbg_win;
    granted  = core_win | dbg_win;
    win_we   = dbg_win ? dbg_we : core_we;
  end
  // memory port and handshake drive; idle cycles present the core's bus
  always_comb begin
    mem_addr    = dbg_win ? dbg_addr : core_addr;
    mem_wr_data = dbg_win ? dbg_wdata : core_wdata;
    mem_wr      = granted & win_we;
    mem_rd      = granted & ~win_we;
    core_stall  = ~reset & core_req & ~core_win;
    dbg_gnt     = dbg_win;
    core_rvalid = ~reset & rd_pend_q & ~rd_owner_q;
    dbg_rvalid  = ~reset & rd_pend_q & rd_owner_q;
    core_rdata  = core_rvalid ? mem_rd_data : '0;
    dbg_rdata   = dbg_rvalid ? mem_rd_data : '0;
  end
  // next state: starvation count only survives while the lock chain continues
  always_comb begin
    last_gnt_d = granted ? dbg_win : last_gnt_q;
    lock_act_d = dbg_win & dbg_lock;
    starve_d   = (core_win | ~lock_act_d) ? 8'd0 :
                 (dbg_win & core_req & lock_act_q & (starve_q != 8'hff)) ? starve_q + 8'd1 : starve_q;
    rd_pend_d  = granted & ~win_we;
    rd_owner_d = dbg_win;
  end
  // state registers; reset leaves the core winning the first conflict
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      lock_act_q <= 1'b0;
      starve_q   <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_act_q <= lock_act_d;
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized check of dmem_arbiter against a rule-level reference model
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_req = 1'b0, core_we = 1'b0, core_stall, core_rvalid;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0, core_rdata;
  logic dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0, dbg_rdata;
  logic mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] env_mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int n_cmp = 0, n_bad = 0;
  int m_last = 1, m_run = 0;
  bit m_lock = 0, m_pv_c = 0, m_pv_d = 0, c_pend = 0, d_pend = 0;
  logic [DW-1:0] m_pdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= env_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst_i, input int p_core, input int p_dbg, input int p_lock);
    bit gc, gd;
    bit exp_cv, exp_dv;
    @(negedge clk);
    reset = rst_i;
    if (!c_pend) begin
      core_req   = $urandom_range(99) < p_core;
      core_we    = 1'($urandom_range(1));
      core_addr  = AW'($urandom_range(15));
      core_wdata = $urandom;
    end
    if (!d_pend) begin
      dbg_req   = $urandom_range(99) < p_dbg;
      dbg_we    = 1'($urandom_range(1));
      dbg_addr  = AW'($urandom_range(15));
      dbg_wdata = $urandom;
    end
    dbg_lock = $urandom_range(99) < p_lock;
    #1;
    gc = 0;
    gd = 0;
    if (!rst_i) begin
      if (core_req && !dbg_req) gc = 1;
      else if (dbg_req && !core_req) gd = 1;
      else if (core_req && dbg_req) begin
        if (m_lock && m_run < ML - 1) gd = 1;
        else if (m_last == 1) gc = 1;
        else gd = 1;
      end
    end
    chk("core_stall", core_stall, core_req && !gc && !rst_i);
    chk("dbg_gnt", dbg_gnt, gd);
    chk("mem_wr", mem_wr, (gc && core_we) || (gd && dbg_we));
    chk("mem_rd", mem_rd, (gc && !core_we) || (gd && !dbg_we));
    if (gd) begin
      chk("mem_addr_dbg", mem_addr, dbg_addr);
      chk("mem_wdata_dbg", mem_wr_data, dbg_wdata);
    end else if (!rst_i) begin
      chk("mem_addr_core", mem_addr, core_addr);
      chk("mem_wdata_core", mem_wr_data, core_wdata);
    end
    exp_cv = !rst_i && m_pv_c;
    exp_dv = !rst_i && m_pv_d;
    chk("core_rvalid", core_rvalid, exp_cv);
    chk("dbg_rvalid", dbg_rvalid, exp_dv);
    chk("core_rdata", core_rdata, exp_cv ? m_pdata : '0);
    chk("dbg_rdata", dbg_rdata, exp_dv ? m_pdata : '0);
    m_pv_c  = gc && !core_we;
    m_pv_d  = gd && !dbg_we;
    m_pdata = gd ? ref_mem[dbg_addr] : ref_mem[core_addr];
    if (gc && core_we) ref_mem[core_addr] = core_wdata;
    if (gd && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
    if (gc || !(gd && dbg_lock)) m_run = 0;
    else if (gd && core_req && m_lock && m_run < 255) m_run++;
    m_lock = gd && dbg_lock;
    if (gc || gd) m_last = gd ? 1 : 0;
    if (rst_i) begin
      m_last = 1;
      m_lock = 0;
      m_run  = 0;
    end
    c_pend = core_req && !gc;
    d_pend = dbg_req && !gd;
  endtask

  task automatic phase(input int n, input int p_core, input int p_dbg, input int p_lock, input int p_rst);
    for (int i = 0; i < n; i++) cycle($urandom_range(99) < p_rst, p_core, p_dbg, p_lock);
  endtask

  initial begin
    phase(3, 50, 50, 50, 100);
    phase(24, 100, 100, 100, 0);
    phase(2, 0, 0, 0, 0);
    phase(400, 50, 50, 50, 2);
    phase(400, 90, 90, 85, 2);
    phase(300, 40, 40, 20, 3);
    phase(200, 100, 100, 100, 1);
    phase(3, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-ported data memory of the `riscv` core. It shares one memory port between the core load/store path and a debug/loader port. Arbitration is round-robin, with an optional debug lock that is bounded by a starvation timer. Read data is routed back to the owner one cycle after the access.

## Interface
Parameters:
- DATA_W, 32, data width of every data bus
- ADDR_W, 9, word address width (matches the core's `addr` port)
- MAX_LOCK, 16, maximum consecutive locked debug grants while the core is waiting (range 2..255)

Ports:
- clk  in  1  clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high
- core_req  in  1  core requests an access this cycle
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  core access address
- core_wdata  in  DATA_W  core store data
- core_stall  out  1  core request not granted this cycle; core must hold its request
- core_rvalid  out  1  core load data valid
- core_rdata  out  DATA_W  core load data
- dbg_req  in  1  debug port requests an access
- dbg_we  in  1  1 = write, 0 = read
- dbg_lock  in  1  debug port asks to keep ownership for the next cycle
- dbg_addr  in  ADDR_W  debug access address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access granted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid one cycle after `mem_rd`

## Operation
State registers:
- `last_gnt`: 0 = core, 1 = dbg.
- `lock_act`: debug lock active.
- `starve_cnt`: 8-bit counter.
- `rd_pend`: a read is pending.
- `rd_owner`: owner of the pending read.

Grant decision is combinational in cycle N:
- Only one requester active: that requester wins.
- Both active, `lock_act`=1 and `starve_cnt` < MAX_LOCK-1: debug wins.
- Both active, otherwise: the requester that is not `last_gnt` wins.
- No requester: no grant, `mem_wr`=`mem_rd`=0, `mem_addr` and `mem_wr_data` hold the core values.

Memory drive:
- The winner's address and write data go to `mem_addr` and `mem_wr_data`.
- `mem_wr` = winner_we; `mem_rd` = ~winner_we.

Handshake outputs:
- `core_stall` = core_req & ~core_granted.
- `dbg_gnt` = dbg granted.
- A stalled requester must hold its request stable; the arbiter does not queue requests.

Register updates at the edge ending cycle N:
- On any grant: `last_gnt` <= winner.
- `lock_act` <= dbg granted & dbg_lock.
- `starve_cnt` increments when debug is granted while core_req=1 and `lock_act`=1. It clears on any core grant and whenever `lock_act` goes to 0. It saturates at 255.
- `rd_pend` <= granted & ~winner_we; `rd_owner` <= winner.

Cycle N+1 read return:
- `core_rvalid` = `rd_pend` & ~`rd_owner`.
- `dbg_rvalid` = `rd_pend` & `rd_owner`.
- Both `rdata` ports are driven from `mem_rd_data`, qualified by their `rvalid`.

Starvation break: once MAX_LOCK-1 locked debug grants have occurred in a row with the core waiting, the next conflict goes to the core, even while `dbg_lock` is held.

## Timing
- Grant is combinational, zero-cycle. An uncontested request is granted in the same cycle, with no stall.
- Reads have a fixed latency of 1 cycle, from the grant cycle to the `rvalid` cycle. Writes complete at the grant edge and produce no response.
- A new access is allowed every cycle, so throughput is 1 access per cycle. A read return in N+1 and a new grant in N+1 may coincide.
- Read-after-write to the same address in consecutive cycles returns the new data, assuming the memory is write-first.
- While reset=1:
  - All grants are 0, `core_stall`=0, `mem_wr`=`mem_rd`=0.
  - Both `rvalid` outputs are 0 and both `rdata` outputs are 0.
  - `last_gnt`<=1, so the core wins the first conflict after reset.
  - `lock_act`<=0, `starve_cnt`<=0, `rd_pend`<=0.
- Reset asserted in cycle N+1 of a read suppresses that read's `rvalid`; the read is lost.
- Deasserting `dbg_lock` ends the lock after the current grant.
- A `dbg_lock` with no `dbg_req` in the following cycle releases the lock: `lock_act` is still 1, but debug is not requesting, so the core wins.

## Test plan
- Uncontested accesses: core store 0xDEADBEEF to 0x010 in cycle 1, then core load 0x010 in cycle 2 -> `core_stall`=0 throughout, `mem_wr`=1 in cycle 1, `core_rvalid`=1 with `core_rdata`=0xDEADBEEF in cycle 3, `dbg_rvalid`=0.
- Conflict round-robin: both request loads for 4 cycles right after reset -> grants alternate core, dbg, core, dbg; `core_stall`=0,1,0,1; each `rvalid` goes to the correct owner one cycle after its grant.
- Debug lock starvation, MAX_LOCK=4: both request continuously, `dbg_lock`=1 -> dbg wins cycles 1-4, core wins cycle 5, dbg wins cycle 6.
- Reset mid-read: debug load granted in cycle N, reset=1 in N+1 -> `dbg_rvalid`=0 in N+1; after reset the first conflict grants the core.
- Back-to-back mixed accesses: core write in N, dbg read of the same address in N+1 -> `dbg_rvalid` in N+2 carries the core's write data.
- Idle cycle: no requests -> `mem_wr`=`mem_rd`=0, no `rvalid`, and `last_gnt`, `lock_act` and `starve_cnt` are unchanged apart from the lock release.
